// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU output UART.
//   uart_state_t       : transmitter FSM states
//   UART_BITS_PER_BYTE : data bits per serial frame
//   TX_IDLE            : idle (mark) level of the serial line
package cpu_io_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

  localparam int   UART_BITS_PER_BYTE = 8;
  localparam logic TX_IDLE            = 1'b1;

endpackage

// File: rtl/cpu_out_fifo.sv
// Synchronous word FIFO with combinational read of the head entry.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push, din     : write request and data; ignored while full
//   pop           : remove head entry; ignored while empty
//   dout          : head entry, valid whenever empty=0
//   count         : entries held (0..DEPTH)
//   full, empty   : decoded from the registered count
module cpu_out_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  // full comes from the registered count, so a push that meets full is
  // dropped even if a pop frees a slot in the same cycle.
  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

endmodule

// File: rtl/cpu_out_uart.sv
// CPU output port to serial line. Words written by the CPU are queued and
// sent as two UART frames each, low byte first (8N1, or 8E1 when the
// CPU_OUT_UART_PARITY_EN macro is defined).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   wr_en, wr_data    : push strobe and word
//   full              : FIFO holds FIFO_DEPTH words
//   overflow          : sticky, a push was dropped while full
//   fifo_count        : words queued (excludes the word being sent)
//   busy              : transmitter not idle
//   tx                : registered serial output, idles high
module cpu_out_uart
  import cpu_io_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          tx
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1   = CW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_BITS_PER_BYTE - 1);

  uart_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic              byte_sel_q, byte_sel_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              pop, empty, last;
  logic [DATA_W-1:0] head;
  logic [7:0]        cur_byte;

  cpu_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign cur_byte = byte_sel_q ? shreg_q[2*UART_BITS_PER_BYTE-1 -: UART_BITS_PER_BYTE]
                               : shreg_q[UART_BITS_PER_BYTE-1:0];
  assign last     = (cnt_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign tx       = tx_q;

  // tx_d is the line level for the current state; registering it puts the
  // line one cycle behind the FSM, which is why the start bit appears the
  // cycle after the pop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_sel_d = byte_sel_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    tx_d       = TX_IDLE;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_d    = head;
          byte_sel_d = 1'b0;
          cnt_d      = DIV_M1;
          state_d    = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (last) begin
          state_d = S_DATA;
          bit_d   = '0;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        tx_d = cur_byte[bit_q];
        if (last) begin
          cnt_d = DIV_M1;
          if (bit_q == LAST_BIT) begin
`ifdef CPU_OUT_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef CPU_OUT_UART_PARITY_EN
      S_PARITY: begin
        tx_d = ^cur_byte;
        if (last) begin
          cnt_d   = DIV_M1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (last) begin
          if (!byte_sel_q) begin
            // High byte follows immediately, no idle gap.
            byte_sel_d = 1'b1;
            cnt_d      = DIV_M1;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_sel_q <= 1'b0;
      shreg_q    <= '0;
      tx_q       <= TX_IDLE;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_sel_q <= byte_sel_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_out_uart.sv
// Bench for cpu_out_uart (CLK_DIV=4, FIFO_DEPTH=8). A line monitor decodes
// frames from tx into words; a word queue holds what should come out.
`timescale 1ns/1ps
module tb_cpu_out_uart;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
`ifdef CPU_OUT_UART_PARITY_EN
  localparam int NB  = 22;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 20;
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full, overflow, busy, tx;
  logic [3:0]  fifo_count;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rx_q[$];
  int          acc_total = 0;
  int          rx_total = 0;
  logic        mon_ab = 1'b0;

  typedef struct {
    logic [15:0] word;
    logic [19:0] seq;     // serial bits without parity, bit 0 sent first
    logic        par_lo;
    logic        par_hi;
  } vec_t;
  vec_t vecs[3];

  always #5 clk = ~clk;

  cpu_out_uart #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .busy       (busy),
    .tx         (tx)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mwait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rst !== 1'b1) mon_ab = 1'b1;
    end
  endtask

  // Line monitor: detects a start bit, samples each bit mid-cell and pairs
  // bytes into words (low byte first). Frames cut by reset are discarded.
  initial begin : monitor
    logic [7:0] b, lo_b;
    logic       lo_v, p, s;
    lo_v = 1'b0;
    lo_b = '0;
    p    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        lo_v = 1'b0;
      end else if (tx === 1'b0) begin
        mon_ab = 1'b0;
        mwait(5);
        b[0] = tx;
        for (int i = 1; i < 8; i++) begin
          mwait(4);
          b[i] = tx;
        end
        mwait(4);
        if (PAR) begin
          p = tx;
          mwait(4);
        end
        s = tx;
        mwait(2);
        if (mon_ab) begin
          lo_v = 1'b0;
        end else begin
          chk("rx_stop_bit", s, 1);
`ifdef CPU_OUT_UART_PARITY_EN
          chk("rx_parity", p, ^b);
`endif
          if (lo_v) begin
            rx_q.push_back({b, lo_b});
            rx_total++;
            lo_v = 1'b0;
          end else begin
            lo_b = b;
            lo_v = 1'b1;
          end
        end
      end
    end
  end

  task automatic idle_wait();
    int t = 0;
    while ((busy !== 1'b0 || fifo_count !== 4'd0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (rx_q.size() < exp_q.size() && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("rx_word_count", rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0)
      chk("rx_word", rx_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    rx_q.delete();
  endtask

  // Cycle-exact check of one word from idle: push at edge N, start bit on
  // tx after N+2, busy low again after N+1+4*NB.
  task automatic run_exact(input vec_t v);
    logic exp_bits[NB];
    int   k = 0;
    for (int i = 0; i < 20; i++) begin
      exp_bits[k] = v.seq[i];
      k++;
      if (PAR && i == 8)  begin exp_bits[k] = v.par_lo; k++; end
      if (PAR && i == 18) begin exp_bits[k] = v.par_hi; k++; end
    end
    wr_en = 1'b1;
    wr_data = v.word;
    @(negedge clk);
    wr_en = 1'b0;
    exp_q.push_back(v.word);
    acc_total++;
    chk("cnt_after_push", fifo_count, 1);
    chk("busy_before_pop", busy, 0);
    chk("tx_idle_before_pop", tx, 1);
    @(negedge clk);
    chk("busy_after_pop", busy, 1);
    chk("cnt_after_pop", fifo_count, 0);
    chk("tx_before_start", tx, 1);
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        @(negedge clk);
        chk($sformatf("tx_bit%0d_word%04h", b, v.word), tx, exp_bits[b]);
        chk("busy_frame", busy, (4 * b + c + 1 < 4 * NB));
      end
    end
    drain(200);
  endtask

  initial begin : main
    logic [15:0] w[10];
    int          cnt_exp[10];
    int          gap, t;
    logic        stay;
    logic        seq7[7];

    vecs[0] = '{16'hA55A, 20'b1101001010_1010110100, 1'b0, 1'b0};
    vecs[1] = '{16'h0301, 20'b1000000110_1000000010, 1'b1, 1'b0};
    vecs[2] = '{16'hFF00, 20'b1111111110_1000000000, 1'b0, 1'b0};
    cnt_exp = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};
    seq7    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", fifo_count, 0);
    rst = 1'b1;
    @(negedge clk);

    // Exact-timing table
    for (int i = 0; i < 3; i++) begin
      run_exact(vecs[i]);
      idle_wait();
    end

    // Back-to-back words; the second push meets the idle pop with count=1
    wr_en = 1'b1;
    wr_data = 16'h0001;
    @(negedge clk);
    chk("b2b_cnt_first", fifo_count, 1);
    wr_data = 16'h0002;
    @(negedge clk);
    wr_en = 1'b0;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    acc_total += 2;
    chk("pushpop_cnt", fifo_count, 1);
    chk("pushpop_busy", busy, 1);
    @(negedge clk);
    chk("pushpop_cnt_hold", fifo_count, 1);
    repeat (4 * NB - 5) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b_gap_tx%0d", i), tx, seq7[i]);
      if (i == 4) begin
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_idle_cnt", fifo_count, 1);
      end
      if (i == 5) begin
        chk("b2b_pop2_busy", busy, 1);
        chk("b2b_pop2_cnt", fifo_count, 0);
      end
    end
    drain(400);
    idle_wait();

    // Fill and overflow: 10 consecutive writes, the 10th is dropped
    for (int j = 0; j < 10; j++) w[j] = 16'($urandom);
    wr_en = 1'b1;
    wr_data = w[0];
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk($sformatf("fill_cnt%0d", j), fifo_count, cnt_exp[j]);
      chk($sformatf("fill_full%0d", j), full, (j >= 8));
      chk($sformatf("fill_ovf%0d", j), overflow, (j == 9));
      if (j < 9) wr_data = w[j + 1];
      else wr_en = 1'b0;
    end
    for (int j = 0; j < 9; j++) exp_q.push_back(w[j]);
    acc_total += 9;
    drain(9 * 4 * NB + 300);
    chk("overflow_sticky", overflow, 1);
    idle_wait();

    // Reset during data bit 3 of the low byte (0xF0 -> bit 3 is 0)
    wr_en = 1'b1;
    wr_data = 16'h5AF0;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (19) @(negedge clk);
    chk("tx_bit3_before_reset", tx, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", fifo_count, 0);
    chk("async_rst_overflow", overflow, 0);
    chk("async_rst_full", full, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    rx_q.delete();
    acc_total = rx_total;
    stay = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) stay = 1'b0;
    end
    chk("tx_idle_after_reset", stay, 1);
    chk("busy_after_reset", busy, 0);

    // Random traffic, kept below the FIFO capacity so nothing is dropped
    for (int i = 0; i < 24; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 150) : $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      t = 0;
      while ((acc_total - rx_total) >= FIFO_DEPTH && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) chk("room_timeout", 0, 1);
      wr_en = 1'b1;
      wr_data = 16'($urandom);
      exp_q.push_back(wr_data);
      acc_total++;
      @(negedge clk);
      wr_en = 1'b0;
    end
    drain(30 * 4 * NB + 500);
    idle_wait();
    chk("rand_no_overflow", overflow, 0);
    chk("rand_cnt_empty", fifo_count, 0);
    chk("rand_tx_idle", tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
